// File: rtl/s_mic_apb_pkg.sv
// Shared MIC packet encodings, header field positions and FSM state type
// for the MIC-to-APB completer bridge.
package s_mic_apb_pkg;

  typedef enum logic [1:0] {
    MIC_RD    = 2'd0,
    MIC_WR    = 2'd1,
    MIC_RDATA = 2'd2,
    MIC_WRACK = 2'd3
  } mic_type_e;

  localparam int HDR_TYPE_LSB = 62;
  localparam int HDR_ID_LSB   = 56;
  localparam int HDR_LEN_LSB  = 48;
  localparam int HDR_ADDR_LSB = 3;
  localparam int ID_W         = 6;
  localparam int LEN_W        = 8;
  localparam int ADDR_W       = 37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WBEAT,
    ST_SETUP,
    ST_ACCESS,
    ST_RHDR,
    ST_RDATA,
    ST_WACK
  } state_e;

  // Response headers always carry a zero address field.
  function automatic logic [63:0] mic_hdr(input mic_type_e t, input logic [ID_W-1:0] id,
                                          input logic [LEN_W-1:0] len);
    mic_hdr = {t, id, len, 48'h0};
  endfunction

endpackage

// File: rtl/s_mic_apb_if.sv
// MIC request/response streams plus the APB3 initiator bus of the bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface s_mic_apb_if #(
  parameter int APB_AW = 13
);
  logic [63:0]       i_tdata;
  logic              i_tvalid;
  logic              i_tready;
  logic              i_tlast;
  logic [63:0]       o_tdata;
  logic              o_tvalid;
  logic              o_tready;
  logic              o_tlast;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;

  modport slave (
    input  i_tdata, i_tvalid, i_tlast,
    output i_tready,
    output o_tdata, o_tvalid, o_tlast,
    input  o_tready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport master (
    output i_tdata, i_tvalid, i_tlast,
    input  i_tready,
    input  o_tdata, o_tvalid, o_tlast,
    output o_tready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/s_mic_apb.sv
// MIC completer that turns each 64-bit request beat into two 32-bit APB
// transfers (low word first). All bus outputs are registered from next-state.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | accept header; stray RDATA/WRACK packets drained
// ST_WBEAT  | accept one write data beat
// ST_SETUP  | APB setup phase for the current half
// ST_ACCESS | APB access phase, waits for PREADY
// ST_RHDR   | send RDATA header
// ST_RDATA  | send one read data beat
// ST_WACK   | send WRACK header
module s_mic_apb
  import s_mic_apb_pkg::*;
#(
  parameter int APB_AW = 13
) (
  input logic          clk,
  input logic          reset,
  s_mic_apb_if.slave   bus
);

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               half_q, half_d;
  logic [63:0]        wdata_q, wdata_d;
  logic               wlast_q, wlast_d;
  logic [63:0]        rbuf_q, rbuf_d;
  logic               skip_q, skip_d;

  logic               i_tready_q, i_tready_d;
  logic               o_tvalid_q, o_tvalid_d;
  logic [63:0]        o_tdata_q, o_tdata_d;
  logic               o_tlast_q, o_tlast_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [APB_AW-1:0]  paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;

  logic               hs_in, hs_out;
  mic_type_e          hdr_type;

  assign hs_in    = bus.i_tvalid && i_tready_q;
  assign hs_out   = o_tvalid_q && bus.o_tready;
  assign hdr_type = mic_type_e'(bus.i_tdata[HDR_TYPE_LSB +: 2]);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    half_d  = half_q;
    wdata_d = wdata_q;
    wlast_d = wlast_q;
    rbuf_d  = rbuf_q;
    skip_d  = skip_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_in) begin
          if (skip_q) begin
            skip_d = !bus.i_tlast;
          end else if (hdr_type == MIC_RD || hdr_type == MIC_WR) begin
            wr_d   = (hdr_type == MIC_WR);
            id_d   = bus.i_tdata[HDR_ID_LSB +: ID_W];
            len_d  = bus.i_tdata[HDR_LEN_LSB +: LEN_W];
            addr_d = bus.i_tdata[HDR_ADDR_LSB +: ADDR_W];
            half_d = 1'b0;
            beat_d = '0;
            if (hdr_type == MIC_RD) state_d = ST_SETUP;
            else                    state_d = bus.i_tlast ? ST_WACK : ST_WBEAT;
          end else begin
            skip_d = !bus.i_tlast;
          end
        end
      end
      ST_WBEAT: begin
        if (hs_in) begin
          wdata_d = bus.i_tdata;
          wlast_d = bus.i_tlast;
          half_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          if (!wr_q) begin
            if (half_q) rbuf_d[63:32] = bus.prdata;
            else        rbuf_d[31:0]  = bus.prdata;
          end
          if (!half_q) begin
            half_d  = 1'b1;
            state_d = ST_SETUP;
          end else begin
            half_d = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
            if (!wr_q) state_d = (beat_q == '0) ? ST_RHDR : ST_RDATA;
            else       state_d = wlast_q ? ST_WACK : ST_WBEAT;
          end
        end
      end
      ST_RHDR: begin
        if (hs_out) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (hs_out) begin
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_WACK: begin
        if (hs_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they appear registered with it.
  always_comb begin
    i_tready_d = 1'b0;
    o_tvalid_d = 1'b0;
    o_tdata_d  = '0;
    o_tlast_d  = 1'b0;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    pwrite_d   = 1'b0;
    paddr_d    = '0;
    pwdata_d   = '0;
    case (state_d)
      ST_IDLE, ST_WBEAT: i_tready_d = 1'b1;
      ST_SETUP, ST_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == ST_ACCESS);
        pwrite_d  = wr_d;
        paddr_d   = APB_AW'({addr_d, half_d, 2'b00});
        pwdata_d  = half_d ? wdata_d[63:32] : wdata_d[31:0];
      end
      ST_RHDR: begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = mic_hdr(MIC_RDATA, id_d, len_d);
      end
      ST_RDATA: begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = rbuf_d;
        o_tlast_d  = (beat_d == len_d);
      end
      ST_WACK: begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = mic_hdr(MIC_WRACK, id_d, LEN_W'(0));
        o_tlast_d  = 1'b1;
      end
      default: i_tready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      half_q     <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      rbuf_q     <= '0;
      skip_q     <= 1'b0;
      i_tready_q <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      half_q     <= half_d;
      wdata_q    <= wdata_d;
      wlast_q    <= wlast_d;
      rbuf_q     <= rbuf_d;
      skip_q     <= skip_d;
      i_tready_q <= i_tready_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  assign bus.i_tready = i_tready_q;
  assign bus.o_tvalid = o_tvalid_q;
  assign bus.o_tdata  = o_tdata_q;
  assign bus.o_tlast  = o_tlast_q;
  assign bus.psel     = psel_q;
  assign bus.penable  = penable_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;

endmodule

// File: tb/tb_s_mic_apb.sv
// Bench for s_mic_apb: directed and random MIC requests against an APB
// memory model and a queue-based reference of expected transfers/responses.
module tb_s_mic_apb;
  localparam int APB_AW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;

  s_mic_apb_if #(.APB_AW(APB_AW)) bus ();
  s_mic_apb #(.APB_AW(APB_AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [12:0] addr; logic wr; logic [31:0] data;} apb_t;
  typedef struct packed {logic [63:0] data; logic last;} rsp_t;

  apb_t        exp_apb [$];
  rsp_t        exp_rsp [$];
  logic [31:0] mem [logic [12:0]];
  int          wait_n   = 0;
  int          ot_stall = 0;

  function automatic logic [31:0] mem_rd(input logic [12:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0193);
  endfunction

  function automatic logic [63:0] hdr(input logic [1:0] t, input logic [5:0] id,
                                     input logic [7:0] len, input logic [39:0] baddr);
    return {t, id, len, 8'h00, baddr[39:3], 3'b000};
  endfunction

  // APB completer with programmable wait states and transfer scoreboard
  initial begin
    int          wcnt = 0;
    logic [12:0] s_addr = '0;
    logic        s_wr = 1'b0;
    logic [31:0] s_wdata = '0;
    apb_t        e;
    bus.pready = 1'b0;
    bus.prdata = '0;
    forever begin
      @(negedge clk);
      bus.pready = 1'b0;
      if (bus.psel && !bus.penable) begin
        s_addr  = bus.paddr;
        s_wr    = bus.pwrite;
        s_wdata = bus.pwdata;
        wcnt    = 0;
        chk("itready_busy", 64'(bus.i_tready), 64'd0);
      end else if (bus.psel && bus.penable) begin
        chk("apb_hold", {bus.paddr, bus.pwrite, bus.pwdata}, {s_addr, s_wr, s_wdata});
        if (wcnt >= wait_n) begin
          bus.pready = 1'b1;
          if (exp_apb.size() == 0) begin
            chk("apb_unexpected", 64'(bus.paddr), 64'hFFFF);
          end else begin
            e = exp_apb.pop_front();
            chk("apb_addr", 64'(bus.paddr), 64'(e.addr));
            chk("apb_wr", 64'(bus.pwrite), 64'(e.wr));
            if (e.wr) chk("apb_wdata", 64'(bus.pwdata), 64'(e.data));
          end
          if (bus.pwrite) mem[bus.paddr] = bus.pwdata;
          else            bus.prdata = mem_rd(bus.paddr);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response sink with back-pressure, stability and content checks
  initial begin
    int          scnt = 0;
    logic        stalled = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_l = 1'b0;
    rsp_t        e;
    bus.o_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled) begin
        chk("rsp_stable_v", 64'(bus.o_tvalid), 64'd1);
        chk("rsp_stable_d", bus.o_tdata, prev_d);
        chk("rsp_stable_l", 64'(bus.o_tlast), 64'(prev_l));
      end
      if (bus.o_tvalid) begin
        if (scnt < ot_stall) begin
          bus.o_tready = 1'b0;
          scnt++;
        end else begin
          bus.o_tready = 1'b1;
          scnt = 0;
        end
      end else begin
        bus.o_tready = ($urandom_range(0, 1) == 1);
      end
      if (bus.o_tvalid && bus.o_tready) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", bus.o_tdata, 64'hDEAD);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", bus.o_tdata, e.data);
          chk("rsp_last", 64'(bus.o_tlast), 64'(e.last));
        end
      end
      stalled = bus.o_tvalid && !bus.o_tready && !reset;
      prev_d  = bus.o_tdata;
      prev_l  = bus.o_tlast;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic last);
    int n = 0;
    bus.i_tdata  = d;
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    while (!bus.i_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_tready) chk("req_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.i_tvalid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] id, input logic [7:0] len, input logic [39:0] baddr);
    logic [39:0] a;
    rsp_t        r;
    apb_t        p;
    r.data = {2'd2, id, len, 48'h0};
    r.last = 1'b0;
    exp_rsp.push_back(r);
    for (int b = 0; b <= int'(len); b++) begin
      a = baddr + 40'(8 * b);
      p.wr = 1'b0;
      p.data = '0;
      p.addr = a[12:0];
      exp_apb.push_back(p);
      p.addr = a[12:0] + 13'd4;
      exp_apb.push_back(p);
      r.data = {mem_rd(a[12:0] + 13'd4), mem_rd(a[12:0])};
      r.last = (b == int'(len));
      exp_rsp.push_back(r);
    end
    send_beat(hdr(2'd0, id, len, baddr), 1'b1);
  endtask

  task automatic do_write(input logic [5:0] id, input logic [39:0] baddr,
                          input logic [63:0] beats [$]);
    logic [39:0] a;
    rsp_t        r;
    apb_t        p;
    for (int b = 0; b < beats.size(); b++) begin
      a = baddr + 40'(8 * b);
      p.wr = 1'b1;
      p.addr = a[12:0];
      p.data = beats[b][31:0];
      exp_apb.push_back(p);
      p.addr = a[12:0] + 13'd4;
      p.data = beats[b][63:32];
      exp_apb.push_back(p);
    end
    r.data = {2'd3, id, 8'd0, 48'h0};
    r.last = 1'b1;
    exp_rsp.push_back(r);
    send_beat(hdr(2'd1, id, 8'($urandom_range(0, 255)), baddr), beats.size() == 0);
    for (int b = 0; b < beats.size(); b++) send_beat(beats[b], b == beats.size() - 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_apb.size() != 0 || !bus.i_tready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pending"}, 64'(exp_rsp.size() + exp_apb.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [63:0] q [$];
    int          n;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_itready", 64'(bus.i_tready), 64'd0);
    chk("rst_otvalid", 64'(bus.o_tvalid), 64'd0);
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_otdata", bus.o_tdata, 64'd0);
    chk("rst_otlast", 64'(bus.o_tlast), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("itready_after_rst", 64'(bus.i_tready), 64'd1);
    @(negedge clk);

    // single read with exact cycle timing
    mem[13'h10] = 32'h1111_1111;
    mem[13'h14] = 32'h2222_2222;
    do_read(6'd5, 8'd0, 40'h10);
    chk("rd_setup_c1", 64'({bus.psel, bus.penable}), 64'b10);
    n = 1;
    while (!bus.o_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_hdr_cycle", 64'(n), 64'd5);
    @(negedge clk);
    chk("rd_beat_c6", bus.o_tdata, 64'h2222_2222_1111_1111);
    wait_idle("rd1");

    // single write with exact cycle timing
    q.delete();
    q.push_back(64'hCAFE_F00D_00AB_CDE0);
    do_write(6'd9, 40'h10, q);
    n = 2;
    while (!bus.o_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ack_cycle", 64'(n), 64'd6);
    wait_idle("wr1");

    do_read(6'd12, 8'd3, 40'h100);
    wait_idle("burst");

    // wait states and back-pressure
    wait_n = 3;
    ot_stall = 5;
    do_read(6'd2, 8'd1, 40'h40);
    wait_idle("wait_rd");
    q.delete();
    q.push_back({$urandom, $urandom});
    q.push_back({$urandom, $urandom});
    do_write(6'd3, 40'h48, q);
    wait_idle("wait_wr");
    wait_n = 0;
    ot_stall = 0;

    // zero-beat write, then stray packets
    q.delete();
    do_write(6'd7, 40'h200, q);
    wait_idle("wr0");
    send_beat(hdr(2'd2, 6'd4, 8'd1, 40'h80), 1'b0);
    send_beat(hdr(2'd0, 6'd4, 8'd0, 40'h88), 1'b1);
    send_beat(hdr(2'd3, 6'd4, 8'd0, 40'h0), 1'b1);
    wait_idle("stray");
    do_read(6'd8, 8'd0, 40'h18);
    wait_idle("after_stray");

    // reset during ACCESS of a burst read
    wait_n = 1000;
    do_read(6'd3, 8'd3, 40'h300);
    n = 0;
    while (!(bus.psel && bus.penable) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_access_seen", 64'(bus.psel && bus.penable), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_psel", 64'(bus.psel), 64'd0);
    chk("mid_rst_penable", 64'(bus.penable), 64'd0);
    chk("mid_rst_otvalid", 64'(bus.o_tvalid), 64'd0);
    @(negedge clk);
    exp_apb.delete();
    exp_rsp.delete();
    wait_n = 0;
    reset = 1'b0;
    @(negedge clk);
    do_read(6'd33, 8'd0, 40'h20);
    wait_idle("after_rst");

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      wait_n   = $urandom_range(0, 2);
      ot_stall = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 0) begin
        do_read(6'($urandom), 8'($urandom_range(0, 3)), 40'($urandom_range(0, 1023)) << 3);
      end else begin
        q.delete();
        for (int b = 0; b < int'($urandom_range(0, 3)); b++) q.push_back({$urandom, $urandom});
        do_write(6'($urandom), 40'($urandom_range(0, 1023)) << 3, q);
      end
      wait_idle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
